is_feeder: RTL
==============

IS_FEEDER -- requirements
Module: is_feeder

Interface
REQ-001 Parameter WIDTH_A, default 16: activation element width.
REQ-002 Parameter WIDTH_B, default 16: weight element width.
REQ-003 Parameter ROWS, default 4: PE rows driven (one act lane and one weight lane per row).
REQ-004 Parameter COLS, default 4: PE columns; activation beats per tile.
REQ-005 Parameter DRAIN, default 8: zero-weight flush cycles after the last weight vector.
REQ-006 Parameter CNT_W, default 8: width of num_vec and internal counters.
REQ-007 Port clk  input  1  single clock; all logic on its rising edge.
REQ-008 Port rst  input  1  reset, synchronous, active-high.
REQ-009 Port start  input  1  tile start pulse.
REQ-010 Port num_vec  input  CNT_W  weight vectors in the tile, sampled on accepted start.
REQ-011 Port act_valid / act_ready  input / output  1 / 1  activation beat handshake.
REQ-012 Port act_data  input  ROWS*WIDTH_A  one activation column; lane r at bits [r*WIDTH_A +: WIDTH_A].
REQ-013 Port wei_valid / wei_ready  input / output  1 / 1  weight beat handshake.
REQ-014 Port wei_data  input  ROWS*WIDTH_B  one weight vector; lane r at bits [r*WIDTH_B +: WIDTH_B].
REQ-015 Port pe_act  output  ROWS*WIDTH_A  activation lanes to the array.
REQ-016 Port pe_cell_sc_en  output  ROWS  activation capture enable per row.
REQ-017 Port pe_wei  output  ROWS*WIDTH_B  skewed weight lanes to the array.
REQ-018 Port pe_pipeline_en, pe_cell_en, pe_reg_clear  output  1 each  array control.
REQ-019 Port busy / done  output  1 / 1  tile in progress / one-cycle completion pulse.

Function
REQ-020 FSM states IDLE, CLEAR, LOAD, STREAM, FLUSH, DONE; registered; all outputs registered.
REQ-021 IDLE: start=1 latches num_vec, -> CLEAR; start while not IDLE ignored.
REQ-022 CLEAR: exactly one cycle pe_reg_clear=1, skew registers zeroed, -> LOAD.
REQ-023 LOAD: act_ready=1; each accepted beat (act_valid&&act_ready) drives pe_act=act_data and pe_cell_sc_en=all ones next cycle; otherwise pe_cell_sc_en=0, pe_act holds.
REQ-024 LOAD exits after COLS accepted beats: -> STREAM if latched num_vec>0, else -> DONE.
REQ-025 STREAM: wei_ready=1; on accepted beat, lane 0 enters skew stage immediately, lane r delayed r advance cycles (ROWS*(ROWS-1)/2 lane registers total).
REQ-026 Skew registers advance only on advance cycles (accepted beat in STREAM, or any FLUSH cycle); otherwise hold (stall).
REQ-027 pe_pipeline_en=pe_cell_en=1 exactly on the cycle following an advance cycle; 0 otherwise.
REQ-028 After num_vec accepted beats -> FLUSH; FLUSH injects zero vectors for ROWS-1+DRAIN consecutive advance cycles, wei_ready=0.
REQ-029 FLUSH -> DONE; DONE: done=1 one cycle, -> IDLE.
REQ-030 busy=1 in every state except IDLE.
REQ-031 act_ready=0 outside LOAD; wei_ready=0 outside STREAM.
REQ-032 Counters saturate-free: beat counter width CNT_W, compared for equality; num_vec=2^CNT_W-1 legal.
REQ-033 Handshakes are valid/ready; data accepted only when both high; feeder never drops or duplicates a beat.

Reset
REQ-034 rst=1 at any time (including mid-tile): next state IDLE; counters and skew registers zero.
REQ-035 Reset values: pe_act=0, pe_wei=0, pe_cell_sc_en=0, pe_pipeline_en=0, pe_cell_en=0, pe_reg_clear=0, act_ready=0, wei_ready=0, busy=0, done=0.
REQ-036 start asserted with rst=1 is ignored.

Verification
REQ-037 ROWS=COLS=4, num_vec=3, valids always high -> pe_reg_clear 1 cycle, 4 pe_cell_sc_en pulses, weight lane 3 of vector 0 appears 3 cycles after lane 0, done after 3+3+8 enable cycles.
REQ-038 wei_valid low 2 cycles mid-STREAM -> pe_pipeline_en low exactly 2 cycles, pe_wei lanes held, no beat lost.
REQ-039 num_vec=0 -> CLEAR, 4 act beats, DONE; pe_pipeline_en never asserted.
REQ-040 rst pulsed during STREAM after 2 vectors -> IDLE next cycle, all outputs at reset values, new start runs a full tile cleanly.
REQ-041 start pulsed during LOAD -> ignored; num_vec change mid-tile has no effect.
REQ-042 act_valid gapped (1 of 3 cycles) -> exactly COLS pe_cell_sc_en pulses, pe_act matches accepted beats in order.

Source files
------------

// File: rtl/is_feeder.sv
// Purpose : input-stationary feeder; loads COLS activation columns into the PE
//           array, then streams num_vec weight vectors through a per-row skew
//           and flushes the skew with zero vectors so every row drains out.
// Latency : accepted beats show up on pe_act / pe_wei lane 0 one cycle later;
//           weight lane r trails lane 0 by r advance cycles.
// Backpressure: act_ready / wei_ready are registered and depend only on state.
//           A missing weight beat stalls the skew and drops the array enables
//           for the following cycle.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, num_vec      tile start pulse; vector count latched on accepted start
//   act_valid/ready/data activation column handshake (lane r at [r*WIDTH_A +: WIDTH_A])
//   wei_valid/ready/data weight vector handshake (lane r at [r*WIDTH_B +: WIDTH_B])
//   pe_act, pe_cell_sc_en activation lanes and per-row capture enables
//   pe_wei              skewed weight lanes
//   pe_pipeline_en, pe_cell_en, pe_reg_clear  array control
//   busy, done          tile in progress / one-cycle completion pulse
module is_feeder #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int DRAIN   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           num_vec,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ROWS*WIDTH_A-1:0]    act_data,
  input  logic                       wei_valid,
  output logic                       wei_ready,
  input  logic [ROWS*WIDTH_B-1:0]    wei_data,
  output logic [ROWS*WIDTH_A-1:0]    pe_act,
  output logic [ROWS-1:0]            pe_cell_sc_en,
  output logic [ROWS*WIDTH_B-1:0]    pe_wei,
  output logic                       pe_pipeline_en,
  output logic                       pe_cell_en,
  output logic                       pe_reg_clear,
  output logic                       busy,
  output logic                       done
);

  // Terminal counts for the shared beat counter. The flush lasts
  // ROWS-1+DRAIN cycles, so its last count is ROWS+DRAIN-2.
  localparam logic [CNT_W-1:0] COLS_LAST  = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROWS + DRAIN - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] nv_q;
  logic [CNT_W-1:0] cnt;

  logic act_acc;
  logic wei_acc;
  logic advance;
  logic skew_clr;

  // The ready flags are registered and only high in their own state, so an
  // accepted beat always belongs to the state that asked for it.
  assign act_acc  = act_valid && act_ready;
  assign wei_acc  = wei_valid && wei_ready;
  assign advance  = wei_acc || (state == S_FLUSH);
  assign skew_clr = (state == S_CLEAR);

  // Control FSM. Every output is set from the transition being taken, so the
  // registered value always matches the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      nv_q           <= '0;
      cnt            <= '0;
      act_ready      <= 1'b0;
      wei_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pe_reg_clear   <= 1'b0;
      pe_cell_sc_en  <= '0;
      pe_act         <= '0;
      pe_pipeline_en <= 1'b0;
      pe_cell_en     <= 1'b0;
    end else begin
      done           <= 1'b0;
      pe_reg_clear   <= 1'b0;
      pe_pipeline_en <= advance;
      pe_cell_en     <= advance;
      pe_cell_sc_en  <= {ROWS{act_acc}};
      if (act_acc) begin
        pe_act <= act_data;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            nv_q         <= num_vec;
            cnt          <= '0;
            state        <= S_CLEAR;
            pe_reg_clear <= 1'b1;
            busy         <= 1'b1;
          end
        end

        S_CLEAR: begin
          state     <= S_LOAD;
          act_ready <= 1'b1;
        end

        S_LOAD: begin
          if (act_acc) begin
            if (cnt == COLS_LAST) begin
              cnt       <= '0;
              act_ready <= 1'b0;
              if (nv_q != '0) begin
                state     <= S_STREAM;
                wei_ready <= 1'b1;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_STREAM: begin
          // nv_q is non-zero here; comparing against nv_q-1 keeps the count
          // below nv_q, so the full CNT_W range of num_vec works.
          if (wei_acc) begin
            if (cnt == nv_q - 1'b1) begin
              cnt       <= '0;
              wei_ready <= 1'b0;
              state     <= S_FLUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Weight skew: lane r passes through r delay registers before its output
  // register, so a vector leaves as a diagonal wavefront. Everything moves
  // only on advance cycles; during the flush zeros are shifted in.
  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    logic [WIDTH_B-1:0] lane_in;
    logic [WIDTH_B-1:0] lane_out;

    assign lane_in = (state == S_FLUSH) ? '0 : wei_data[g*WIDTH_B +: WIDTH_B];
    assign pe_wei[g*WIDTH_B +: WIDTH_B] = lane_out;

    if (g == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst || skew_clr) begin
          lane_out <= '0;
        end else if (advance) begin
          lane_out <= lane_in;
        end
      end
    end else begin : g_delay
      logic [WIDTH_B-1:0] dly [g];

      always_ff @(posedge clk) begin
        if (rst || skew_clr) begin
          for (int k = 0; k < g; k++) begin
            dly[k] <= '0;
          end
          lane_out <= '0;
        end else if (advance) begin
          dly[0] <= lane_in;
          for (int k = 1; k < g; k++) begin
            dly[k] <= dly[k-1];
          end
          lane_out <= dly[g-1];
        end
      end
    end
  end

endmodule
